sram_access_ctrl: RTL and testbench

Sequences single SRAM macro accesses. Accepts read/write requests over a valid/ready handshake and drives the array-side controls in phase order: bitline precharge, row address plus decoder enable (wordline), sense-amp enable, then a response. It sits between the host request logic and the row decoder / bitline / sense-amp circuitry, producing the address and enable that the row decoder consumes.

---
 rtl/sram_access_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// Single-access SRAM macro sequencer.
// Accepts one read/write request over a valid/ready handshake. It then steps
// the array through bitline precharge, wordline (row decoder enable), sense
// (reads only) and a held response.
//
// Optional feature: define SRAM_PARITY_EN to add an even-parity bit (MSB) on
// wr_data/sense_data and report read parity errors on rsp_err.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (req_we, req_addr, req_wdata)
//   rsp_valid/rsp_ready      response handshake (rsp_rdata, rsp_err)
//   row_addr, row_en         row decoder address and enable
//   pre_en                   bitline precharge
//   wr_en, wr_data           bitline write drivers
//   sense_en, sense_data     sense-amp enable and outputs
module sram_access_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PRE_CYCLES   = 1,
    parameter int unsigned WL_CYCLES    = 2,
    parameter int unsigned SENSE_CYCLES = 1,
`ifdef SRAM_PARITY_EN
    localparam int unsigned BUS_W = DATA_WIDTH + 1
`else
    localparam int unsigned BUS_W = DATA_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] row_addr,
    output logic                  row_en,
    output logic                  pre_en,
    output logic                  wr_en,
    output logic [BUS_W-1:0]      wr_data,
    output logic                  sense_en,
    input  logic [BUS_W-1:0]      sense_data
);

    localparam int unsigned MAX_PW  = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_PW > SENSE_CYCLES) ? MAX_PW : SENSE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        WL    = 3'd2,
        SENSE = 3'd3,
        RESP  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic                  row_en_q, row_en_d;
    logic                  pre_en_q, pre_en_d;
    logic                  wr_en_q, wr_en_d;
    logic [BUS_W-1:0]      wr_data_q, wr_data_d;
    logic                  sense_en_q, sense_en_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef SRAM_PARITY_EN
    logic                  rsp_err_q, rsp_err_d;
`endif

    // Next-state, phase counter, request latch and registered output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        row_addr_d  = row_addr_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef SRAM_PARITY_EN
        rsp_err_d   = rsp_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    wdata_d    = req_wdata;
                    row_addr_d = req_addr;
                    cnt_d      = CNT_W'(PRE_CYCLES - 1);
                    state_d    = PRE;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(WL_CYCLES - 1);
                    state_d = WL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WL: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        // Write acknowledge carries no data and no error
                        rsp_rdata_d = '0;
`ifdef SRAM_PARITY_EN
                        rsp_err_d   = 1'b0;
`endif
                        state_d     = RESP;
                    end else begin
                        cnt_d   = CNT_W'(SENSE_CYCLES - 1);
                        state_d = SENSE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SENSE: begin
                if (cnt_q == '0) begin
                    // Sample the sense amps on the edge that ends the sense phase
                    rsp_rdata_d = sense_data[DATA_WIDTH-1:0];
`ifdef SRAM_PARITY_EN
                    rsp_err_d   = ^sense_data;
`endif
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they flop in phase with it
        pre_en_d    = (state_d == PRE);
        row_en_d    = (state_d == WL) || (state_d == SENSE);
        wr_en_d     = (state_d == WL) && we_d;
        sense_en_d  = (state_d == SENSE);
        rsp_valid_d = (state_d == RESP);
`ifdef SRAM_PARITY_EN
        wr_data_d   = wr_en_d ? {^wdata_d, wdata_d} : '0;
`else
        wr_data_d   = wr_en_d ? wdata_d : '0;
`endif
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            row_addr_q  <= '0;
            row_en_q    <= 1'b0;
            pre_en_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            sense_en_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef SRAM_PARITY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            row_addr_q  <= row_addr_d;
            row_en_q    <= row_en_d;
            pre_en_q    <= pre_en_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            sense_en_q  <= sense_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef SRAM_PARITY_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Ready is blocked while reset is held so no request lands on a reset edge
    assign req_ready = (state_q == IDLE) && !rst;

    assign row_addr  = row_addr_q;
    assign row_en    = row_en_q;
    assign pre_en    = pre_en_q;
    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign sense_en  = sense_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef SRAM_PARITY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: a cycle-window reference model
// plus directed accesses with hand-computed expectations.
module tb_sram_access_ctrl;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int P  = 1;
    localparam int W  = 2;
    localparam int S  = 1;
`ifdef SRAM_PARITY_EN
    localparam int BW = DW + 1;
`else
    localparam int BW = DW;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] row_addr;
    logic          row_en;
    logic          pre_en;
    logic          wr_en;
    logic [BW-1:0] wr_data;
    logic          sense_en;
    logic [BW-1:0] sense_data;

    int checks = 0;
    int errors = 0;

    sram_access_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .PRE_CYCLES  (P),
        .WL_CYCLES   (W),
        .SENSE_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .row_addr  (row_addr),
        .row_en    (row_en),
        .pre_en    (pre_en),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .sense_en  (sense_en),
        .sense_data(sense_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: an access is a window of cycles counted from the accept
    // edge (cycle 1 = first cycle after accept). Phases are plain ranges.
    logic          m_started = 1'b0;
    logic          m_busy    = 1'b0;
    logic          m_resp    = 1'b0;
    int            m_cyc     = 0;
    logic          m_we      = 1'b0;
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_wdata   = '0;
    logic [DW-1:0] m_rdata   = '0;
    logic          m_err     = 1'b0;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (rst) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_addr = '0;
            m_cyc  = 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  = 1'b1;
                m_resp  = 1'b0;
                m_cyc   = 1;
                m_we    = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
            end
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_busy = 1'b0;
                m_resp = 1'b0;
            end
        end else begin
            m_cyc = m_cyc + 1;
            if (m_cyc == (m_we ? P + W + 1 : P + W + S + 1)) begin
                m_resp = 1'b1;
                if (m_we) begin
                    m_rdata = '0;
                    m_err   = 1'b0;
                end else begin
                    m_rdata = sense_data[DW-1:0];
`ifdef SRAM_PARITY_EN
                    m_err   = ^sense_data;
`else
                    m_err   = 1'b0;
`endif
                end
            end
        end
    end

    // Compare process: every cycle, mid-period
    logic          e_act;
    logic [BW-1:0] e_wd;
    always @(negedge clk) begin
        if (m_started) begin
            e_act = m_busy && !m_resp;
`ifdef SRAM_PARITY_EN
            e_wd  = {^m_wdata, m_wdata};
`else
            e_wd  = m_wdata;
`endif
            chk("req_ready", 32'(req_ready), 32'(!m_busy && !rst));
            chk("pre_en",    32'(pre_en),    32'(e_act && m_cyc <= P));
            chk("row_en",    32'(row_en),    32'(e_act && m_cyc > P));
            chk("wr_en",     32'(wr_en),     32'(e_act && m_we && m_cyc > P));
            chk("sense_en",  32'(sense_en),  32'(e_act && !m_we && m_cyc > P + W));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
            chk("row_addr",  32'(row_addr),  32'(m_addr));
            if (e_act && m_we && m_cyc > P) chk("wr_data", 32'(wr_data), 32'(e_wd));
            if (m_resp) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
                chk("rsp_err",   32'(rsp_err),   32'(m_err));
            end
        end
    end

    // Sample point: 1 time unit after the rising edge; inputs change here too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] wl_addr;
    logic [BW-1:0] wl_wdata;

    // One full access with literal latency / phase-length / data expectations
    task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [BW-1:0] sd, input int hold, input int exp_lat,
                          input logic [DW-1:0] exp_rd, input logic exp_err);
        int n;
        int lat;
        int pre_n;
        int wr_n;
        int sen_n;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        sense_data = sd;
        rsp_ready  = (hold == 0);
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1; pre_n = 0; wr_n = 0; sen_n = 0;
        while (!rsp_valid && lat < 40) begin
            if (lat == P + 1) begin
                wl_addr  = row_addr;
                wl_wdata = wr_data;
            end
            chk("overlap", 32'(pre_en && row_en), 32'd0);
            pre_n += int'(pre_en);
            wr_n  += int'(wr_en);
            sen_n += int'(sense_en);
            step();
            lat++;
        end
        chk("latency",   32'(lat),   32'(exp_lat));
        chk("pre_len",   32'(pre_n), 32'd1);
        chk("wr_len",    32'(wr_n),  we ? 32'd2 : 32'd0);
        chk("sense_len", 32'(sen_n), we ? 32'd0 : 32'd1);
        chk("rdata",     32'(rsp_rdata), 32'(exp_rd));
        chk("err",       32'(rsp_err),   32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", 32'(rsp_rdata), 32'(exp_rd));
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_ctrl",  32'({row_en, pre_en, wr_en, sense_en}), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; sense_data = '0;
        wl_addr = '0; wl_wdata = '0;
        step();
        step();
        chk("rst_ctrl",  32'({row_en, pre_en, wr_en, sense_en, rsp_valid, rsp_err}), 32'd0);
        chk("rst_addr",  32'(row_addr), 32'd0);
        chk("rst_wdata", 32'(wr_data),  32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Write 0x2A <- 0xA5 (even number of ones, so parity bit 0 either way)
        access(1'b1, 6'h2A, 8'hA5, BW'(0), 0, 4, 8'h00, 1'b0);
        chk("wl_addr_w",  32'(wl_addr),  32'h2A);
        chk("wl_wdata_w", 32'(wl_wdata), 32'hA5);

        // Read 0x3F, sense 0x5C
        access(1'b0, 6'h3F, 8'h00, BW'(8'h5C), 0, 5, 8'h5C, 1'b0);
        chk("wl_addr_r", 32'(wl_addr), 32'h3F);

        // Read with 5 cycles of response backpressure (0x5C has even parity)
        access(1'b0, 6'h15, 8'h00, BW'(8'h5C), 5, 5, 8'h5C, 1'b0);

        // Reset in the middle of a read's wordline phase
        req_we = 1'b0; req_addr = 6'h0C; sense_data = BW'(8'h3C); req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("rst_mid_wl", 32'(row_en), 32'd1);
        rst = 1'b1;
        step();
        chk("abort_ctrl",  32'({row_en, sense_en, rsp_valid}), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("abort_ready2", 32'(req_ready), 32'd1);
        step();
        step();
        chk("abort_norsp", 32'(rsp_valid), 32'd0);

        // Second request raised during the first access's wordline phase
        req_we = 1'b0; req_addr = 6'h10; sense_data = BW'(8'h99); req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        req_we = 1'b1; req_addr = 6'h01; req_wdata = 8'h33; req_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("busy_addr", 32'(row_addr), 32'h10);
            step();
            n++;
        end
        chk("busy_rdata", 32'(rsp_rdata), 32'h99);
        step();
        chk("busy_idle_ready", 32'(req_ready), 32'd1);
        chk("busy_idle_addr",  32'(row_addr),  32'h10);
        step();
        req_valid = 1'b0;
        chk("busy_accept_addr", 32'(row_addr), 32'h01);
        chk("busy_accept_pre",  32'(pre_en),   32'd1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("busy_second_rsp", 32'(rsp_valid), 32'd1);
        step();

`ifdef SRAM_PARITY_EN
        access(1'b1, 6'h05, 8'h07, BW'(0), 0, 4, 8'h00, 1'b0);
        chk("par_gen", 32'(wl_wdata), 32'h107);
        access(1'b0, 6'h05, 8'h00, BW'(9'h107), 0, 5, 8'h07, 1'b0);
        access(1'b0, 6'h05, 8'h00, BW'(9'h007), 0, 5, 8'h07, 1'b1);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
